lfsr_run_controller: RTL and testbench
======================================

Name: lfsr_run_controller

Overview:
Sequencer for the LFSR pattern-hunt datapath. It replaces the divided-clock scheme with a single-clock step enable and drives the LFSR load and step strobes. It counts detector hits per run, captures the final count when the LFSR completes a full cycle, and hands the result to the display path with a valid/ack handshake.

Parameters:
TICK_DIV, 5000, CCLK cycles per LFSR step (≥2)
NUM_DET, 6, number of pattern-detector hit inputs
CW, 15, match counter and result width

Ports:
CCLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
ENGAGE  in  1  run request level; 1 = run, 0 = pause or stop
CLEAR  in  1  synchronous abort pulse
full_cycle  in  1  LFSR has returned to seed state (from LFSR)
match_in  in  NUM_DET  detector hit flags
result_ack  in  1  display path has consumed result
lfsr_load  out  1  one-cycle LFSR seed-load strobe
lfsr_step  out  1  one-cycle LFSR shift enable
match_count  out  CW  live hit count of the current run
result  out  CW  captured count of the last completed run
result_valid  out  1  result pending, held until ack
busy  out  1  high in LOAD, RUN and HOLD
state  out  3  current FSM state encoding

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, prescaler=0. All outputs are 0.
- Priority, highest first: RESET, CLEAR, FSM transitions. A CLEAR edge puts state=IDLE, clears match_count, result, result_valid and the prescaler, and forces lfsr_load and lfsr_step to 0 on the next cycle.
- Outputs are registered. Strobes are exactly 1 cycle wide.
- States:
  - IDLE (0): while ENGAGE=1, go to LOAD.
  - LOAD (1): lfsr_load=1, match_count←0, prescaler←0. Go to RUN unconditionally.
  - RUN (2): the prescaler increments each cycle. When it reaches TICK_DIV-1 it wraps to 0 and raises tick.
    - On a tick, lfsr_step=1 in the following cycle.
    - On a tick, if |match_in then match_count += 1, saturating at 2^CW-1. Multiple simultaneous hits count as one.
    - On a tick with full_cycle=1, result←updated count (including that tick's hit), result_valid←1, go to REPORT.
    - If there is no tick-with-full_cycle and ENGAGE=0, go to HOLD.
    - full_cycle and match_in are ignored on non-tick cycles and outside RUN.
  - HOLD (3): the prescaler and count are frozen and no strobes are issued. ENGAGE=1 returns to RUN, and the prescaler resumes from its held value.
  - REPORT (4): result_valid stays 1 and result is stable. On result_ack=1 the next cycle has result_valid=0. The FSM then goes to LOAD if ENGAGE=1, otherwise to IDLE. result keeps its value until the next capture, CLEAR or reset.
- Simultaneous events:
  - A tick with full_cycle=1 and ENGAGE=0 goes to REPORT.
  - result_ack outside REPORT is ignored.
- Encodings 5–7 are illegal and recover to IDLE.
- Latency:
  - ENGAGE rises in IDLE → lfsr_load at cycle +2 (IDLE→LOAD registered).
  - First lfsr_step arrives TICK_DIV cycles after entering RUN, plus 1 registered cycle.

Decomposition:
- Shared package lfsr_ctrl_pkg holds the state encodings (IDLE/LOAD/RUN/HOLD/REPORT), the default TICK_DIV, and the CW/NUM_DET defaults. The display controller also uses CW from this package.
- One sub-module: tick_prescaler. It has inputs CCLK, RESET, en and clr, parameter TICK_DIV, and outputs tick and a count value. The FSM, counter and handshake stay in the top-level module.

Test Plan (all with TICK_DIV=4, NUM_DET=6, CW=15 unless noted):
- Reset mid-RUN with match_count=9: drive RESET=0 → state=0, match_count=0 and all strobes 0 within the same cycle, asynchronously. Release with ENGAGE=1 → lfsr_load pulses once 2 cycles later.
- Step cadence: ENGAGE held high for 40 cycles → exactly one lfsr_load, then lfsr_step pulses spaced exactly 4 cycles apart. busy=1 throughout.
- Hit counting: match_in=6'b000101 on 3 ticks and 6'b000000 on 2 ticks → match_count=3. Hits on non-tick cycles do not count.
- Saturation (CW=3): 9 ticks each with a hit → match_count stops at 7.
- Capture and handshake: count=5, then a tick with full_cycle=1 and a hit → result=6 and result_valid=1. result_valid holds for 10 cycles with no ack. Ack with ENGAGE=0 → result_valid=0 and state=IDLE, result stays 6.
- Pause and abort:
  - ENGAGE dropped at prescaler=2 and held low 10 cycles → state=HOLD, no lfsr_step. After ENGAGE rises, the next lfsr_step comes 2 RUN cycles after re-entry plus 1.
  - A CLEAR pulse in HOLD → state=IDLE and match_count=0.

Source files
------------

// File: rtl/lfsr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_ctrl_pkg
// Shared definitions for the LFSR pattern-hunt control path: FSM state
// encodings, default step divider and the counter/result width that the
// display controller also uses.
// -----------------------------------------------------------------------------
package lfsr_ctrl_pkg;

  localparam int DEF_TICK_DIV = 5000;  // CCLK cycles per LFSR step
  localparam int DEF_NUM_DET  = 6;     // pattern-detector hit inputs
  localparam int DEF_CW       = 15;    // match counter / result width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_HOLD   = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  // busy covers every state in which a run is in progress
  function automatic logic is_busy(input state_t s);
    return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/lfsr_run_controller_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Single-clock step-enable generator. Counts enabled cycles from 0 to
// TICK_DIV-1; the cycle in which it sits at TICK_DIV-1 with en=1 raises tick
// and wraps the count to 0. clr has priority over en; with en=0 the count is
// frozen.
//
// Ports:
//   CCLK   in   system clock
//   RESET  in   asynchronous active-low reset
//   en     in   advance the count this cycle
//   clr    in   synchronous return to 0
//   tick   out  combinational, high on the wrapping cycle
//   count  out  current prescaler value
// -----------------------------------------------------------------------------
module tick_prescaler
  import lfsr_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int PW       = $clog2(TICK_DIV)
) (
  input  logic          CCLK,
  input  logic          RESET,
  input  logic          en,
  input  logic          clr,
  output logic          tick,
  output logic [PW-1:0] count
);

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == PW'(TICK_DIV - 1));
  assign tick   = en && w_last;
  assign count  = r_cnt;

  always_ff @(posedge CCLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/lfsr_run_controller.sv
// -----------------------------------------------------------------------------
// lfsr_run_controller
// Sequencer for the LFSR pattern-hunt datapath. Issues the LFSR seed-load and
// step strobes from a single-clock prescaler, counts detector hits once per
// step, captures the count when the LFSR completes a cycle and holds it for
// the display path until acknowledged.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for ENGAGE
// LOAD   | seed the LFSR, clear count and prescaler
// RUN    | prescaler running, one LFSR step and hit sample per tick
// HOLD   | paused by ENGAGE=0, prescaler and count frozen
// REPORT | result_valid held until result_ack
//
// Ports:
//   CCLK, RESET          clock, asynchronous active-low reset
//   ENGAGE               run request level
//   CLEAR                synchronous abort pulse
//   full_cycle           LFSR back at seed state
//   match_in[NUM_DET]    detector hit flags
//   result_ack           display path consumed result
//   lfsr_load/lfsr_step  one-cycle registered strobes
//   match_count[CW]      live hit count
//   result[CW]           captured count of last completed run
//   result_valid, busy   handshake flag, run-in-progress flag
//   state[3]             current FSM encoding
// -----------------------------------------------------------------------------
module lfsr_run_controller
  import lfsr_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int NUM_DET  = DEF_NUM_DET,
  parameter int CW       = DEF_CW
) (
  input  logic               CCLK,
  input  logic               RESET,
  input  logic               ENGAGE,
  input  logic               CLEAR,
  input  logic               full_cycle,
  input  logic [NUM_DET-1:0] match_in,
  input  logic               result_ack,
  output logic               lfsr_load,
  output logic               lfsr_step,
  output logic [CW-1:0]      match_count,
  output logic [CW-1:0]      result,
  output logic               result_valid,
  output logic               busy,
  output logic [2:0]         state
);

  localparam int PSC_W = $clog2(TICK_DIV);

  state_t          r_state;
  state_t          w_next;
  logic            r_load;
  logic            r_step;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_result;
  logic            r_valid;
  logic            r_busy;

  logic [PSC_W-1:0] w_psc_cnt;
  logic             w_psc_last;
  logic             w_psc_en;
  logic             w_psc_clr;
  logic             w_tick;
  logic             w_hit;
  logic             w_capture;
  logic [CW-1:0]    w_count_upd;

  // The prescaler freezes when ENGAGE drops, except on its wrapping cycle:
  // that tick is still honoured so a full_cycle arriving together with the
  // ENGAGE drop reaches REPORT.
  assign w_psc_last = (w_psc_cnt == PSC_W'(TICK_DIV - 1));
  assign w_psc_en   = (r_state == ST_RUN) && (ENGAGE || w_psc_last);
  assign w_psc_clr  = CLEAR || (r_state == ST_LOAD);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PW       (PSC_W)
  ) u_prescaler (
    .CCLK  (CCLK),
    .RESET (RESET),
    .en    (w_psc_en),
    .clr   (w_psc_clr),
    .tick  (w_tick),
    .count (w_psc_cnt)
  );

  // Any number of simultaneous detector hits counts as a single hit.
  always_comb begin
    w_hit       = |match_in;
    w_count_upd = r_count;
    if (w_hit && !(&r_count)) begin
      w_count_upd = r_count + CW'(1);
    end
    w_capture = (r_state == ST_RUN) && w_tick && full_cycle;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ENGAGE) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_capture)    w_next = ST_REPORT;
        else if (!ENGAGE) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (ENGAGE) w_next = ST_RUN;
      end
      ST_REPORT: begin
        if (result_ack) w_next = ENGAGE ? ST_LOAD : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (CLEAR) w_next = ST_IDLE;
  end

  always_ff @(posedge CCLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_load   <= 1'b0;
      r_step   <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (CLEAR) begin
      r_state  <= ST_IDLE;
      r_load   <= 1'b0;
      r_step   <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= is_busy(w_next);
      r_load  <= (r_state == ST_LOAD);
      r_step  <= w_tick;

      if (r_state == ST_LOAD) begin
        r_count <= '0;
      end else if (w_tick) begin
        r_count <= w_count_upd;
      end

      if (w_capture) begin
        r_result <= w_count_upd;
        r_valid  <= 1'b1;
      end else if ((r_state == ST_REPORT) && result_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign lfsr_load    = r_load;
  assign lfsr_step    = r_step;
  assign match_count  = r_count;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign busy         = r_busy;
  assign state        = r_state;

endmodule

// File: tb/tb_lfsr_run_controller.sv
module tb_lfsr_run_controller;

  logic        CCLK = 1'b0;
  logic        RESET = 1'b0;
  logic        ENGAGE = 1'b0;
  logic        CLEAR = 1'b0;
  logic        full_cycle = 1'b0;
  logic [5:0]  match_in = '0;
  logic        result_ack = 1'b0;

  logic        load, step, valid, busy;
  logic [14:0] mc, res;
  logic [2:0]  st;

  logic        s_load, s_step, s_valid, s_busy;
  logic [2:0]  s_mc, s_res;
  logic [2:0]  s_st;

  lfsr_run_controller #(.TICK_DIV(4), .NUM_DET(6), .CW(15)) dut (
    .CCLK(CCLK), .RESET(RESET), .ENGAGE(ENGAGE), .CLEAR(CLEAR),
    .full_cycle(full_cycle), .match_in(match_in), .result_ack(result_ack),
    .lfsr_load(load), .lfsr_step(step), .match_count(mc), .result(res),
    .result_valid(valid), .busy(busy), .state(st)
  );

  lfsr_run_controller #(.TICK_DIV(4), .NUM_DET(6), .CW(3)) dut_sat (
    .CCLK(CCLK), .RESET(RESET), .ENGAGE(ENGAGE), .CLEAR(CLEAR),
    .full_cycle(full_cycle), .match_in(match_in), .result_ack(result_ack),
    .lfsr_load(s_load), .lfsr_step(s_step), .match_count(s_mc), .result(s_res),
    .result_valid(s_valid), .busy(s_busy), .state(s_st)
  );

  always #5 CCLK = ~CCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge CCLK);
    #1;
  endtask

  // Leaves the DUT in RUN, prescaler at 0, immediately after the LOAD->RUN edge.
  task automatic start_run();
    CLEAR = 1'b1; ENGAGE = 1'b0;
    clk_step();
    CLEAR = 1'b0; ENGAGE = 1'b1;
    clk_step();
    chk("start_load_state", st, 1);
    clk_step();
    chk("start_run_state", st, 2);
    chk("start_load_pulse", load, 1);
  endtask

  // Three non-tick cycles then the tick cycle (prescaler 0,1,2 then 3).
  task automatic run_tick(input logic [5:0] nt_m, input logic nt_fc,
                          input logic [5:0] t_m, input logic t_fc, input logic ack);
    match_in = nt_m; full_cycle = nt_fc; result_ack = ack;
    repeat (3) clk_step();
    match_in = t_m; full_cycle = t_fc;
    clk_step();
    match_in = '0; full_cycle = 1'b0; result_ack = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  nt_m;
    logic        nt_fc;
    logic [5:0]  t_m;
    logic        t_fc;
    logic        ack;
    logic [14:0] e_cnt;
    logic [2:0]  e_st;
    logic        e_valid;
    logic [14:0] e_res;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_load, load_c, n_stp, first_step, last_step, busy_bad, exp_sat;

    vt[0] = '{6'h00, 1'b0, 6'h05, 1'b0, 1'b0, 15'd1, 3'd2, 1'b0, 15'd0};
    vt[1] = '{6'h3F, 1'b1, 6'h00, 1'b0, 1'b0, 15'd1, 3'd2, 1'b0, 15'd0};
    vt[2] = '{6'h00, 1'b0, 6'h05, 1'b0, 1'b0, 15'd2, 3'd2, 1'b0, 15'd0};
    vt[3] = '{6'h3F, 1'b0, 6'h00, 1'b0, 1'b1, 15'd2, 3'd2, 1'b0, 15'd0};
    vt[4] = '{6'h00, 1'b0, 6'h05, 1'b0, 1'b0, 15'd3, 3'd2, 1'b0, 15'd0};
    vt[5] = '{6'h00, 1'b0, 6'h3F, 1'b0, 1'b0, 15'd4, 3'd2, 1'b0, 15'd0};
    vt[6] = '{6'h00, 1'b0, 6'h01, 1'b0, 1'b0, 15'd5, 3'd2, 1'b0, 15'd0};
    vt[7] = '{6'h00, 1'b0, 6'h20, 1'b1, 1'b0, 15'd6, 3'd4, 1'b1, 15'd6};

    // reset state
    repeat (3) clk_step();
    chk("rst_state", st, 0);
    chk("rst_load", load, 0);
    chk("rst_step", step, 0);
    chk("rst_count", mc, 0);
    chk("rst_result", res, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);

    // step cadence
    RESET = 1'b1; ENGAGE = 1'b1;
    n_load = 0; load_c = 0; n_stp = 0; first_step = 0; last_step = 0; busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      clk_step();
      if (load === 1'b1) begin n_load++; load_c = c; end
      if (step === 1'b1) begin
        if (last_step > 0) chk("step_gap", c - last_step, 4);
        else first_step = c;
        n_stp++;
        last_step = c;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    chk("cad_load_count", n_load, 1);
    chk("cad_load_cycle", load_c, 2);
    chk("cad_first_step", first_step, 6);
    chk("cad_step_count", n_stp, 9);
    chk("cad_busy_low_cycles", busy_bad, 0);

    // hit counting and capture
    start_run();
    for (int i = 0; i < 8; i++) begin
      run_tick(vt[i].nt_m, vt[i].nt_fc, vt[i].t_m, vt[i].t_fc, vt[i].ack);
      chk($sformatf("vec%0d_count", i), mc, vt[i].e_cnt);
      chk($sformatf("vec%0d_state", i), st, vt[i].e_st);
      chk($sformatf("vec%0d_valid", i), valid, vt[i].e_valid);
      chk($sformatf("vec%0d_result", i), res, vt[i].e_res);
      chk($sformatf("vec%0d_step", i), step, 1);
    end

    // result held without ack, then ack with ENGAGE=0
    ENGAGE = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clk_step();
      chk("rep_hold_valid", valid, 1);
      chk("rep_hold_state", st, 4);
      chk("rep_hold_result", res, 6);
    end
    result_ack = 1'b1;
    clk_step();
    result_ack = 1'b0;
    chk("ack_valid", valid, 0);
    chk("ack_state", st, 0);
    chk("ack_result", res, 6);
    clk_step();
    chk("post_ack_state", st, 0);
    chk("post_ack_result", res, 6);
    chk("post_ack_busy", busy, 0);
    chk("post_ack_load", load, 0);

    // pause at prescaler=2
    start_run();
    clk_step();
    clk_step();
    ENGAGE = 1'b0; match_in = 6'h3F;
    clk_step();
    for (int k = 0; k < 10; k++) begin
      chk("hold_state", st, 3);
      chk("hold_step", step, 0);
      chk("hold_count", mc, 0);
      chk("hold_busy", busy, 1);
      if (k < 9) clk_step();
    end
    ENGAGE = 1'b1; match_in = '0;
    clk_step();
    chk("resume_state", st, 2);
    chk("resume_step0", step, 0);
    clk_step();
    chk("resume_step1", step, 0);
    match_in = 6'h01;
    clk_step();
    match_in = '0;
    chk("resume_step2", step, 1);
    chk("resume_count", mc, 1);

    // CLEAR in HOLD
    ENGAGE = 1'b0;
    clk_step();
    chk("pre_abort_state", st, 3);
    chk("pre_abort_count", mc, 1);
    CLEAR = 1'b1;
    clk_step();
    CLEAR = 1'b0;
    chk("abort_state", st, 0);
    chk("abort_count", mc, 0);
    chk("abort_load", load, 0);
    chk("abort_step", step, 0);
    chk("abort_busy", busy, 0);

    // saturation on the CW=3 instance
    start_run();
    for (int k = 1; k <= 9; k++) begin
      run_tick(6'h00, 1'b0, 6'h10, 1'b0, 1'b0);
      exp_sat = (k > 7) ? 7 : k;
      chk($sformatf("sat_count_k%0d", k), s_mc, exp_sat);
      chk($sformatf("wide_count_k%0d", k), mc, k);
    end

    // asynchronous reset mid-RUN with count=9, step currently high
    chk("pre_rst_step", step, 1);
    #2 RESET = 1'b0;
    #1;
    chk("arst_state", st, 0);
    chk("arst_count", mc, 0);
    chk("arst_load", load, 0);
    chk("arst_step", step, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sat_count", s_mc, 0);
    #1 RESET = 1'b1; ENGAGE = 1'b1;
    clk_step();
    chk("rel_load_c1", load, 0);
    chk("rel_state_c1", st, 1);
    clk_step();
    chk("rel_load_c2", load, 1);
    clk_step();
    chk("rel_load_c3", load, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
